// File: rtl/matrix_input_loader.sv
// Byte-serial loader for the 3x3 multiplier operands: captures A then B row-major and
// presents them as flat buses. Optional trailing XOR checksum byte under INPUT_CHECKSUM_EN.
`default_nettype none

module matrix_input_loader #(
  parameter int DATA_W = 8,
  parameter int DIM    = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                input_en,
  input  logic                                data_valid,
  input  logic [DATA_W-1:0]                   data_in,
  output logic                                ready,
  output logic [$clog2(2*DIM*DIM+2)-1:0]      load_count,
  output logic [DATA_W*DIM*DIM-1:0]           a_flat,
  output logic [DATA_W*DIM*DIM-1:0]           b_flat,
  output logic                                input_done,
  output logic                                checksum_err
);

  localparam int NELEM = DIM * DIM;
  localparam int CNT_W = $clog2(2 * DIM * DIM + 2);
  localparam int BUS_W = DATA_W * NELEM;

  localparam logic [CNT_W-1:0] LAST_A  = CNT_W'(NELEM - 1);
  localparam logic [CNT_W-1:0] LAST_B  = CNT_W'(2 * NELEM - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic             ready_r;
  logic             done_r;
  logic             accept_s;
  logic [CNT_W-1:0] count_r;
  logic [BUS_W-1:0] a_r;
  logic [BUS_W-1:0] b_r;

  // ready_r mirrors the load states, so this is exactly the accept condition
  assign accept_s = ready_r & input_en & data_valid;

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (input_en) state_nxt_s = S_LOAD_A;
        else          state_nxt_s = S_IDLE;
      end
      S_LOAD_A: begin
        if (!input_en)                          state_nxt_s = S_IDLE;
        else if (accept_s && count_r == LAST_A) state_nxt_s = S_LOAD_B;
        else                                    state_nxt_s = S_LOAD_A;
      end
      S_LOAD_B: begin
        if (!input_en) begin
          state_nxt_s = S_IDLE;
        end else if (accept_s && count_r == LAST_B) begin
`ifdef INPUT_CHECKSUM_EN
          state_nxt_s = S_CHECK;
`else
          state_nxt_s = S_DONE;
`endif
        end else begin
          state_nxt_s = S_LOAD_B;
        end
      end
      S_CHECK: begin
        if (!input_en)    state_nxt_s = S_IDLE;
        else if (accept_s) state_nxt_s = S_DONE;
        else              state_nxt_s = S_CHECK;
      end
      S_DONE: begin
        if (!input_en) state_nxt_s = S_IDLE;
        else           state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, status flags and byte counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      count_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == S_LOAD_A) || (state_nxt_s == S_LOAD_B) ||
                 (state_nxt_s == S_CHECK);
      done_r  <= (state_nxt_s == S_DONE);
      // count freezes in DONE because ready_r is low there
      if (state_r == S_IDLE) begin
        if (input_en) count_r <= '0;
        else          count_r <= count_r;
      end else if (ready_r && !input_en) begin
        count_r <= '0;
      end else if (accept_s) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Element capture: load_count selects the A or B slot
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      for (int k = 0; k < NELEM; k++) begin
        if (accept_s && state_r == S_LOAD_A && count_r == CNT_W'(k))
          a_r[k*DATA_W +: DATA_W] <= data_in;
        if (accept_s && state_r == S_LOAD_B && count_r == CNT_W'(k + NELEM))
          b_r[k*DATA_W +: DATA_W] <= data_in;
      end
    end
  end

`ifdef INPUT_CHECKSUM_EN
  logic [DATA_W-1:0] xor_r;
  logic              err_r;

  function automatic logic byte_mismatch(input logic [DATA_W-1:0] x,
                                         input logic [DATA_W-1:0] y);
    return |(x ^ y);
  endfunction

  // Running XOR of data bytes, compared against the trailing checksum byte
  always_ff @(posedge clk) begin
    if (rst) begin
      xor_r <= '0;
      err_r <= 1'b0;
    end else if (state_r == S_IDLE && input_en) begin
      xor_r <= '0;
      err_r <= 1'b0;
    end else if (accept_s && state_r == S_CHECK) begin
      err_r <= byte_mismatch(xor_r, data_in);
    end else if (accept_s) begin
      xor_r <= xor_r ^ data_in;
    end else begin
      xor_r <= xor_r;
    end
  end

  assign checksum_err = err_r;
`else
  assign checksum_err = 1'b0;
`endif

  assign ready      = ready_r;
  assign load_count = count_r;
  assign a_flat     = a_r;
  assign b_flat     = b_r;
  assign input_done = done_r;

endmodule

`default_nettype wire

// File: tb/tb_matrix_input_loader.sv
// Directed self-checking bench for matrix_input_loader; also covers the INPUT_CHECKSUM_EN build.
`timescale 1ns/1ps

module tb_matrix_input_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        input_en;
  logic        data_valid;
  logic [7:0]  data_in;
  logic        ready;
  logic [4:0]  load_count;
  logic [71:0] a_flat;
  logic [71:0] b_flat;
  logic        input_done;
  logic        checksum_err;

  int errors = 0;
  int checks = 0;
  logic [71:0] exp_a;
  logic [71:0] exp_b;

`ifdef INPUT_CHECKSUM_EN
  localparam logic [4:0] FINAL_CNT = 5'd19;
`else
  localparam logic [4:0] FINAL_CNT = 5'd18;
`endif

  always #5 clk = ~clk;

  matrix_input_loader dut (
    .clk          (clk),
    .rst          (rst),
    .input_en     (input_en),
    .data_valid   (data_valid),
    .data_in      (data_in),
    .ready        (ready),
    .load_count   (load_count),
    .a_flat       (a_flat),
    .b_flat       (b_flat),
    .input_done   (input_done),
    .checksum_err (checksum_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic v);
    data_in    = b;
    data_valid = v;
    tick();
  endtask

  // 18 bytes base, base+1, ...; optional 0xFF filler with data_valid=0 between bytes.
  // In the checksum build a trailing checksum (true XOR ^ mask) is sent.
  task automatic load_bytes(input logic [7:0] base, input logic gap, input logic [7:0] mask);
    logic [7:0] b;
    logic [7:0] xs;
    xs = 8'h00;
    for (int i = 0; i < 18; i++) begin
      b = base + 8'(i);
      if (i < 9) exp_a[i*8 +: 8] = b;
      else       exp_b[(i-9)*8 +: 8] = b;
      xs = xs ^ b;
      send(b, 1'b1);
      if (gap && i != 17) send(8'hFF, 1'b0);
    end
`ifdef INPUT_CHECKSUM_EN
    chk("done_before_ck", {71'd0, input_done}, 72'd0);
    chk("ready_in_check", {71'd0, ready}, 72'd1);
    send(xs ^ mask, 1'b1);
`else
    xs = xs ^ mask;
`endif
    data_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; input_en = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    exp_a = 72'd0; exp_b = 72'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    // reset state
    chk("rst_ready", {71'd0, ready}, 72'd0);
    chk("rst_done",  {71'd0, input_done}, 72'd0);
    chk("rst_count", {67'd0, load_count}, 72'd0);
    chk("rst_a",     a_flat, 72'd0);
    chk("rst_b",     b_flat, 72'd0);
    chk("rst_err",   {71'd0, checksum_err}, 72'd0);

    // data_valid ignored in IDLE
    send(8'h77, 1'b1);
    data_valid = 1'b0;
    chk("idle_a", a_flat, 72'd0);

    // plain back-to-back load 1..18
    input_en = 1'b1;
    tick();
    chk("load_ready", {71'd0, ready}, 72'd1);
    chk("load_count0", {67'd0, load_count}, 72'd0);
    load_bytes(8'd1, 1'b0, 8'h00);
    chk("t2_done",  {71'd0, input_done}, 72'd1);
    chk("t2_count", {67'd0, load_count}, {67'd0, FINAL_CNT});
    chk("t2_a0",    {64'd0, a_flat[7:0]},   72'd1);
    chk("t2_a8",    {64'd0, a_flat[71:64]}, 72'd9);
    chk("t2_b0",    {64'd0, b_flat[7:0]},   72'd10);
    chk("t2_b8",    {64'd0, b_flat[71:64]}, 72'd18);
    chk("t2_a",     a_flat, 72'h09_08_07_06_05_04_03_02_01);
    chk("t2_b",     b_flat, 72'h12_11_10_0F_0E_0D_0C_0B_0A);
    chk("t2_ready", {71'd0, ready}, 72'd0);
    chk("t2_err",   {71'd0, checksum_err}, 72'd0);

    // extra bytes in DONE are dropped
    for (int i = 0; i < 4; i++) begin
      send(8'h55, 1'b1);
      chk("t5_done",  {71'd0, input_done}, 72'd1);
      chk("t5_a",     a_flat, exp_a);
      chk("t5_b",     b_flat, exp_b);
      chk("t5_count", {67'd0, load_count}, {67'd0, FINAL_CNT});
    end
    data_valid = 1'b0;
    input_en = 1'b0;
    chk("t5_done_hold", {71'd0, input_done}, 72'd1);
    tick();
    chk("t5_done_drop", {71'd0, input_done}, 72'd0);
    chk("t5_ready", {71'd0, ready}, 72'd0);
    chk("t5_a_keep", a_flat, exp_a);

    // toggling data_valid with 0xFF on invalid cycles
    exp_a = 72'd0; exp_b = 72'd0;
    input_en = 1'b1;
    tick();
    load_bytes(8'd1, 1'b1, 8'h00);
    chk("t3_a",     a_flat, 72'h09_08_07_06_05_04_03_02_01);
    chk("t3_b",     b_flat, 72'h12_11_10_0F_0E_0D_0C_0B_0A);
    chk("t3_done",  {71'd0, input_done}, 72'd1);
    chk("t3_count", {67'd0, load_count}, {67'd0, FINAL_CNT});

    // abort after 5 bytes, then reload 0xA0..0xB1
    input_en = 1'b0;
    tick();
    input_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i), 1'b1);
    data_valid = 1'b0;
    chk("t4_count5", {67'd0, load_count}, 72'd5);
    input_en = 1'b0;
    tick();
    chk("t4_abort_done",  {71'd0, input_done}, 72'd0);
    chk("t4_abort_count", {67'd0, load_count}, 72'd0);
    chk("t4_abort_ready", {71'd0, ready}, 72'd0);
    chk("t4_partial_a0",  {64'd0, a_flat[7:0]},   72'h31);
    chk("t4_partial_a4",  {64'd0, a_flat[39:32]}, 72'h35);
    chk("t4_partial_a5",  {64'd0, a_flat[47:40]}, 72'h06);
    input_en = 1'b1;
    tick();
    chk("t4_idle_done", {71'd0, input_done}, 72'd0);
    load_bytes(8'hA0, 1'b0, 8'h00);
    chk("t4_a0",    {64'd0, a_flat[7:0]},   72'hA0);
    chk("t4_b8",    {64'd0, b_flat[71:64]}, 72'hB1);
    chk("t4_a",     a_flat, exp_a);
    chk("t4_b",     b_flat, exp_b);
    chk("t4_count", {67'd0, load_count}, {67'd0, FINAL_CNT});
    chk("t4_done",  {71'd0, input_done}, 72'd1);

    // checksum: correct 0x13 was sent above for 1..18; now send 0x00 (0x13 ^ 0x13)
    input_en = 1'b0;
    tick();
    input_en = 1'b1;
    tick();
    load_bytes(8'd1, 1'b0, 8'h13);
    chk("t6_done", {71'd0, input_done}, 72'd1);
`ifdef INPUT_CHECKSUM_EN
    chk("t6_err_bad", {71'd0, checksum_err}, 72'd1);
`else
    chk("t6_err_tied", {71'd0, checksum_err}, 72'd0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_err",  {71'd0, checksum_err}, 72'd0);
    chk("t6_rst_done", {71'd0, input_done}, 72'd0);

    // reset in the middle of a load
    tick();
    for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), 1'b1);
    data_valid = 1'b0;
    chk("mid_count3", {67'd0, load_count}, 72'd3);
    chk("mid_a",      a_flat, 72'h00_00_00_00_00_00_C2_C1_C0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", {71'd0, ready}, 72'd0);
    chk("mid_rst_count", {67'd0, load_count}, 72'd0);
    chk("mid_rst_a",     a_flat, 72'd0);
    tick();
    chk("mid_reload_ready", {71'd0, ready}, 72'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
